dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported 32-entry data memory. It shares the memory between the CPU load/store stage (port C) and the debug/loader port (port D). It drives the memory's active-low write strobe and its registered-address read protocol, and returns read data with a valid pulse. Port C has fixed priority, with a starvation guard that guarantees port D service.

## Interface
- ADDR_W, 5, word address width (memory depth 2^ADDR_W)
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive C grants allowed while D waits before D is forced through (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- c_req  in  1  port C request; hold until c_gnt
- c_we  in  1  1 = store, 0 = load
- c_addr  in  ADDR_W  word address
- c_wdata  in  DATA_W  store data
- c_gnt  out  1  one-cycle grant pulse
- c_rvalid  out  1  one-cycle load-data-valid pulse
- c_rdata  out  DATA_W  load data, valid when c_rvalid
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: identical set for port D
- mem_wren  out  1  to memory: 0 = write w_data at w_addr; 1 = latch r_addr
- mem_r_addr  out  ADDR_W  memory read address
- mem_w_addr  out  ADDR_W  memory write address
- mem_w_data  out  DATA_W  memory write data
- mem_r_data  in  DATA_W  memory read data; reflects the address latched at the previous edge

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- IDLE: if any req is high, pick a winner and latch {port, we, addr, wdata} into internal registers, then go to ACCESS. With no request, stay in IDLE.
- Winner selection:
  - C wins if c_req and not (d_req and starve_cnt == STARVE_LIMIT).
  - Otherwise D wins if d_req.
- starve_cnt, evaluated at each IDLE decision:
  - C granted while d_req high: increment, saturating at STARVE_LIMIT.
  - D granted, or d_req low: clear to 0.
- ACCESS:
  - The winner's gnt is 1 for exactly this cycle.
  - mem_r_addr and mem_w_addr = latched addr; mem_w_data = latched wdata.
  - Store: mem_wren = 0, so the write commits at the ACCESS→next edge; next state IDLE.
  - Load: mem_wren = 1, so the memory latches the address at the edge; next state RDATA.
- RDATA: mem_wren = 1. The winner's rvalid = 1 and rdata = mem_r_data, combinational passthrough. Next state IDLE.
- Outside ACCESS (store), mem_wren is always 1. No write can occur outside a granted store.
- Requesters may drop req or change payload the cycle after gnt. Payload is latched at the decision edge, so later changes have no effect.
- The non-selected rdata output holds its last value. Only rvalid qualifies rdata.

## Timing
- Reset values (async, immediate on rst_n low):
  - state = IDLE, starve_cnt = 0.
  - c_gnt = d_gnt = 0, c_rvalid = d_rvalid = 0, c_rdata = d_rdata = 0.
  - mem_wren = 1, mem_r_addr = mem_w_addr = 0, mem_w_data = 0.
- Store latency:
  - req high before edge E0 → gnt high in cycle E0–E1 → memory written at E1.
  - Occupancy is 2 cycles (IDLE + ACCESS).
- Load latency:
  - gnt in cycle E0–E1 → rvalid/rdata in cycle E1–E2.
  - Occupancy is 3 cycles.
- Back-to-back: the next decision is taken at the edge that leaves ACCESS (store) or RDATA (load). A continuously requesting port therefore sees gnt every 2 (store) or 3 (load) cycles.
- Simultaneous c_req and d_req: C wins unless the guard fires.
  - With both requesting continuously, D gets one grant after every STARVE_LIMIT C grants.
- Store followed by load to the same address returns the new data. The write commits before the load's ACCESS.
- Reset mid-ACCESS store: mem_wren goes to 1 immediately, and the write is dropped if rst_n falls before the edge.
- Reset mid-RDATA: rvalid drops immediately, and the load is lost. Requesters must reissue.
- rst_n deassertion is synchronized externally. The first decision is taken at the first edge with rst_n high.

## Test plan
- Reset: hold rst_n = 0 with c_req = d_req = 1 → all gnt/rvalid 0, mem_wren = 1, addresses/data 0. Release → C granted at the first edge.
- C store then load: store addr 5 = 0xDEADBEEF, then load addr 5 → c_gnt pulses, mem_wren = 0 for exactly one cycle, c_rvalid one cycle after the load gnt with c_rdata = 0xDEADBEEF.
- D load of addr 31 previously written 0x12345678 via D → d_rvalid with d_rdata = 0x12345678. c_gnt and c_rvalid stay 0 throughout.
- Contention, STARVE_LIMIT = 4, both req held high (loads) → grant order C,C,C,C,D,C,C,C,C,D, with gnt every 3 cycles.
- Payload change after gnt: C store addr 3 = 0xA, then change c_addr/c_wdata to 7/0xB the cycle after c_gnt → memory addr 3 = 0xA and addr 7 unchanged.
- Reset mid-ACCESS of a D store of 0xFFFFFFFF to addr 9 (rst_n low before the edge) → mem_wren returns to 1 at once. After release, a load of addr 9 returns its prior value.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Port C has fixed priority; a starvation counter forces port D through after STARVE_LIMIT C wins.
module dmem_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDATA  = 2'd2;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [1:0]        state_r, state_nx_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic              port_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              c_gnt_r, d_gnt_r;
  logic              c_rvalid_r, d_rvalid_r;
  logic              mem_wren_r;
  logic [DATA_W-1:0] c_rdata_r, d_rdata_r;

  logic              guard_s, c_win_s, d_win_s, take_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Arbitration decision and selected payload for the IDLE edge
  always_comb begin
    guard_s     = d_req && (starve_cnt_r == LIMIT_C);
    c_win_s     = c_req && !guard_s;
    d_win_s     = !c_win_s && d_req;
    take_s      = (state_r == ST_IDLE) && (c_win_s || d_win_s);
    sel_we_s    = c_win_s ? c_we    : d_we;
    sel_addr_s  = c_win_s ? c_addr  : d_addr;
    sel_wdata_s = c_win_s ? c_wdata : d_wdata;
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) state_nx_s = ST_ACCESS;
        else        state_nx_s = ST_IDLE;
      end
      ST_ACCESS: begin
        if (we_r) state_nx_s = ST_IDLE;
        else      state_nx_s = ST_RDATA;
      end
      ST_RDATA: state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Sequencer registers; gnt/wren/rvalid are registered so they line up with ACCESS/RDATA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
      port_r       <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      c_gnt_r      <= 1'b0;
      d_gnt_r      <= 1'b0;
      c_rvalid_r   <= 1'b0;
      d_rvalid_r   <= 1'b0;
      mem_wren_r   <= 1'b1;
      c_rdata_r    <= {DATA_W{1'b0}};
      d_rdata_r    <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      c_gnt_r    <= 1'b0;
      d_gnt_r    <= 1'b0;
      c_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      mem_wren_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            port_r     <= d_win_s;
            we_r       <= sel_we_s;
            addr_r     <= sel_addr_s;
            wdata_r    <= sel_wdata_s;
            c_gnt_r    <= c_win_s;
            d_gnt_r    <= d_win_s;
            mem_wren_r <= !sel_we_s;
          end
          // Count only C wins taken while D was waiting
          if (c_win_s && d_req) begin
            if (starve_cnt_r != LIMIT_C) starve_cnt_r <= starve_cnt_r + CNT_W'(1);
          end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_ACCESS: begin
          if (!we_r) begin
            c_rvalid_r <= !port_r;
            d_rvalid_r <= port_r;
          end
        end
        ST_RDATA: begin
          if (c_rvalid_r) c_rdata_r <= mem_r_data;
          if (d_rvalid_r) d_rdata_r <= mem_r_data;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign c_gnt      = c_gnt_r;
  assign d_gnt      = d_gnt_r;
  assign c_rvalid   = c_rvalid_r;
  assign d_rvalid   = d_rvalid_r;
  assign c_rdata    = c_rvalid_r ? mem_r_data : c_rdata_r;
  assign d_rdata    = d_rvalid_r ? mem_r_data : d_rdata_r;
  assign mem_wren   = mem_wren_r;
  assign mem_r_addr = addr_r;
  assign mem_w_addr = addr_r;
  assign mem_w_data = wdata_r;

endmodule
